// File: rtl/chacha_if.sv
// Request/response bundle for the ChaCha block core: key material and counter
// control in, one 512-bit keystream block out under a valid/ready handshake.
interface chacha_if #(
  parameter int CTR_W = 64
);
  localparam int NONCE_W = 128 - CTR_W;

  logic [255:0]         key;
  logic [NONCE_W-1:0]   nonce;
  logic [CTR_W-1:0]     ctr_init;
  logic                 ctr_load;
  logic                 start;
  logic                 in_ready;
  logic [511:0]         block;
  logic                 out_valid;
  logic                 out_ready;
  logic                 ctr_wrap;

  modport master (
    output key, nonce, ctr_init, ctr_load, start, out_ready,
    input  in_ready, block, out_valid, ctr_wrap
  );

  modport slave (
    input  key, nonce, ctr_init, ctr_load, start, out_ready,
    output in_ready, block, out_valid, ctr_wrap
  );
endinterface

// File: rtl/chacha_core_param.sv
// Parameterised ChaCha block core: one column or diagonal round per clock,
// so a block is ready ROUNDS cycles after the start is accepted.
module chacha_core_param #(
  parameter int ROUNDS = 20,
  parameter int CTR_W  = 64
) (
  input logic     clk,
  input logic     rst,
  chacha_if.slave bus
);
  localparam int NONCE_W = 128 - CTR_W;
  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_core_param: ROUNDS must be 8, 12 or 20");
  end
  if (!(CTR_W == 32 || CTR_W == 64)) begin : g_bad_ctr_w
    $error("chacha_core_param: CTR_W must be 32 or 64");
  end

  typedef enum logic [1:0] {IDLE, COL, DIAG, HOLD} state_t;

  state_t             r_state;
  logic [4:0]         r_rc;
  logic [CTR_W-1:0]   r_ctr;
  logic [31:0]        r_x    [16];
  logic [31:0]        r_init [16];
  logic [511:0]       r_block;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_ctr_wrap;

  logic [NONCE_W-1:0] w_nonce;
  logic [CTR_W-1:0]   w_ctr_use;
  logic [127:0]       w_tail;
  logic               w_accept;
  logic [31:0]        w_st   [16];
  logic [31:0]        w_col  [16];
  logic [31:0]        w_diag [16];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Returns {d, c, b, a} after one full quarter-round.
  function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  // A load coinciding with an accept supplies the counter for that very block.
  assign w_nonce   = bus.nonce;
  assign w_ctr_use = bus.ctr_load ? bus.ctr_init : r_ctr;
  assign w_tail    = {w_nonce, w_ctr_use};
  assign w_accept  = (r_state == IDLE) && bus.start;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_st[i]      = SIGMA[32*i +: 32];
      w_st[12 + i] = w_tail[32*i +: 32];
    end
    for (int j = 0; j < 8; j++) begin
      w_st[4 + j] = bus.key[32*j +: 32];
    end
  end

  always_comb begin
    logic [127:0] q;
    // NOTE: every output gets a default up front so no path can infer a latch.
    q = '0;
    for (int i = 0; i < 16; i++) begin
      w_col[i]  = '0;
      w_diag[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      q = qr(r_x[i], r_x[4 + i], r_x[8 + i], r_x[12 + i]);
      w_col[i]      = q[31:0];
      w_col[4 + i]  = q[63:32];
      w_col[8 + i]  = q[95:64];
      w_col[12 + i] = q[127:96];

      q = qr(r_x[i], r_x[4 + (i + 1) % 4], r_x[8 + (i + 2) % 4], r_x[12 + (i + 3) % 4]);
      w_diag[i]                = q[31:0];
      w_diag[4 + (i + 1) % 4]  = q[63:32];
      w_diag[8 + (i + 2) % 4]  = q[95:64];
      w_diag[12 + (i + 3) % 4] = q[127:96];
    end
  end

  // NOTE: the working and initial state arrays carry no reset; they are always
  // reloaded on accept before use, so resetting them would only add fan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rc        <= '0;
      r_ctr       <= '0;
      r_block     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_ctr_wrap  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees pre-edge values.
      r_ctr_wrap <= 1'b0;
      if (w_accept) begin
        r_ctr      <= w_ctr_use + CTR_W'(1);
        r_ctr_wrap <= &w_ctr_use;
      end else if (bus.ctr_load) begin
        r_ctr <= bus.ctr_init;
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_x        <= w_st;
            r_init     <= w_st;
            r_rc       <= '0;
            r_in_ready <= 1'b0;
            r_state    <= COL;
          end
        end
        COL: begin
          r_x     <= w_col;
          r_state <= DIAG;
        end
        DIAG: begin
          r_x  <= w_diag;
          r_rc <= r_rc + 5'd2;
          if (r_rc + 5'd2 < 5'(ROUNDS)) begin
            r_state <= COL;
          end else begin
            for (int i = 0; i < 16; i++) begin
              r_block[32*i +: 32] <= w_diag[i] + r_init[i];
            end
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.block     = r_block;
  assign bus.out_valid = r_out_valid;
  assign bus.ctr_wrap  = r_ctr_wrap;
endmodule

// File: tb/tb_chacha_core_param.sv
// Directed bench for chacha_core_param: four builds (20/32, 20/64, 8/64, 12/32)
// checked against RFC 8439 words and a behavioural ChaCha reference.
module tb_chacha_core_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] t_key      [4];
  logic [95:0]  t_nonce    [4];
  logic [63:0]  t_ctr_init [4];
  logic         t_load     [4];
  logic         t_start    [4];
  logic         t_oready   [4];
  wire  [511:0] t_block    [4];
  wire          t_valid    [4];
  wire          t_inrdy    [4];
  wire          t_wrap     [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int R = (g == 2) ? 8 : (g == 3) ? 12 : 20;
    localparam int C = (g == 1 || g == 2) ? 64 : 32;
    chacha_if #(.CTR_W(C)) u_if ();
    chacha_core_param #(.ROUNDS(R), .CTR_W(C)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
    );
    assign u_if.key       = t_key[g];
    assign u_if.nonce     = t_nonce[g][128-C-1:0];
    assign u_if.ctr_init  = t_ctr_init[g][C-1:0];
    assign u_if.ctr_load  = t_load[g];
    assign u_if.start     = t_start[g];
    assign u_if.out_ready = t_oready[g];
    assign t_block[g]     = u_if.block;
    assign t_valid[g]     = u_if.out_valid;
    assign t_inrdy[g]     = u_if.in_ready;
    assign t_wrap[g]      = u_if.ctr_wrap;
  end

  localparam int QIDX [32] = '{0, 4, 8, 12,  1, 5, 9, 13,  2, 6, 10, 14,  3, 7, 11, 15,
                               0, 5, 10, 15, 1, 6, 11, 12, 2, 7, 8, 13,   3, 4, 9, 14};

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [63:0] c, input int cw, input int rounds);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [31:0] a, b, cc, d;
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4 + j] = k[32*j +: 32];
    s[12] = c[31:0];
    if (cw == 64) begin
      s[13] = c[63:32]; s[14] = n[31:0]; s[15] = n[63:32];
    end else begin
      s[13] = n[31:0]; s[14] = n[63:32]; s[15] = n[95:64];
    end
    x = s;
    for (int rr = 0; rr < rounds; rr += 2) begin
      for (int q = 0; q < 8; q++) begin
        a = x[QIDX[4*q]]; b = x[QIDX[4*q+1]]; cc = x[QIDX[4*q+2]]; d = x[QIDX[4*q+3]];
        a = a + b;  d = rl(d ^ a, 16);
        cc = cc + d; b = rl(b ^ cc, 12);
        a = a + b;  d = rl(d ^ a, 8);
        cc = cc + d; b = rl(b ^ cc, 7);
        x[QIDX[4*q]] = a; x[QIDX[4*q+1]] = b; x[QIDX[4*q+2]] = cc; x[QIDX[4*q+3]] = d;
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // One block on DUT idx; optional ctr_load of mid_val while in flight at cycle mid_at.
  task automatic run_block(input int idx, input bit load, input logic [63:0] cinit,
                           input int lat, input int mid_at, input logic [63:0] mid_val,
                           output logic [511:0] blk, output int wraps);
    int cnt;
    wraps = 0;
    @(posedge clk); #1;
    n_checks++;
    if (t_inrdy[idx] !== 1'b1) begin
      n_fail++; $display("FAIL run_in_ready[%0d]: got %b want 1", idx, t_inrdy[idx]);
    end
    t_ctr_init[idx] = cinit; t_load[idx] = load; t_start[idx] = 1'b1;
    @(posedge clk); #1;
    t_start[idx] = 1'b0; t_load[idx] = 1'b0;
    cnt = 0;
    while (t_valid[idx] !== 1'b1 && cnt < 200) begin
      if (t_wrap[idx] === 1'b1) wraps++;
      if (cnt == mid_at) begin
        t_load[idx] = 1'b1; t_ctr_init[idx] = mid_val;
      end else begin
        t_load[idx] = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
    end
    t_load[idx] = 1'b0;
    n_checks++;
    if (cnt != lat) begin
      n_fail++; $display("FAIL latency[%0d]: got %0d want %0d", idx, cnt, lat);
    end
    blk = t_block[idx];
    t_oready[idx] = 1'b1;
    @(posedge clk); #1;
    t_oready[idx] = 1'b0;
    n_checks++;
    if (t_valid[idx] !== 1'b0 || t_inrdy[idx] !== 1'b1) begin
      n_fail++; $display("FAIL release[%0d]: valid=%b in_ready=%b want 0/1", idx, t_valid[idx], t_inrdy[idx]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (t_inrdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, t_inrdy[i]); end
      n_checks++;
      if (t_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", i, t_valid[i]); end
      n_checks++;
      if (t_block[i] !== 512'd0) begin n_fail++; $display("FAIL reset_block[%0d]: got %h want 0", i, t_block[i]); end
      n_checks++;
      if (t_wrap[i] !== 1'b0) begin n_fail++; $display("FAIL reset_wrap[%0d]: got %b want 0", i, t_wrap[i]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_rfc_vector();
    logic [511:0] blk;
    int w;
    for (int j = 0; j < 32; j++) t_key[0][8*j +: 8] = 8'(j);
    t_nonce[0] = {32'h00000000, 32'h4a000000, 32'h09000000};
    run_block(0, 1'b1, 64'd1, 20, -1, 64'd0, blk, w);
    n_checks++;
    if (blk[31:0] !== 32'he4e7f110) begin n_fail++; $display("FAIL rfc_word0: got %h want e4e7f110", blk[31:0]); end
    n_checks++;
    if (blk !== ref_block(t_key[0], t_nonce[0], 64'd1, 32, 20)) begin
      n_fail++; $display("FAIL rfc_block: got %h want %h", blk, ref_block(t_key[0], t_nonce[0], 64'd1, 32, 20));
    end
    n_checks++;
    if (w != 0) begin n_fail++; $display("FAIL rfc_wrap: got %0d want 0", w); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] blk;
    int w;
    t_key[1] = '0; t_nonce[1] = '0;
    run_block(1, 1'b1, 64'd0, 20, -1, 64'd0, blk, w);
    n_checks++;
    if (blk[31:0] !== 32'hade0b876) begin n_fail++; $display("FAIL zero_ctr0_word0: got %h want ade0b876", blk[31:0]); end
    n_checks++;
    if (blk !== ref_block(256'd0, 96'd0, 64'd0, 64, 20)) begin n_fail++; $display("FAIL zero_ctr0_block: got %h", blk); end
    run_block(1, 1'b0, 64'd0, 20, -1, 64'd0, blk, w);
    n_checks++;
    if (blk[31:0] !== 32'hbee7079f) begin n_fail++; $display("FAIL zero_ctr1_word0: got %h want bee7079f", blk[31:0]); end
    n_checks++;
    if (blk !== ref_block(256'd0, 96'd0, 64'd1, 64, 20)) begin n_fail++; $display("FAIL zero_ctr1_block: got %h", blk); end
  endtask

  task automatic test_wrap();
    logic [511:0] blk;
    int w;
    run_block(1, 1'b1, {64{1'b1}}, 20, -1, 64'd0, blk, w);
    n_checks++;
    if (w != 1) begin n_fail++; $display("FAIL wrap_pulse: got %0d pulses want 1", w); end
    n_checks++;
    if (blk !== ref_block(256'd0, 96'd0, {64{1'b1}}, 64, 20)) begin n_fail++; $display("FAIL wrap_block_max: got %h", blk); end
    run_block(1, 1'b0, 64'd0, 20, -1, 64'd0, blk, w);
    n_checks++;
    if (w != 0) begin n_fail++; $display("FAIL wrap_second: got %0d pulses want 0", w); end
    n_checks++;
    if (blk[31:0] !== 32'hade0b876) begin n_fail++; $display("FAIL wrap_ctr0_word0: got %h want ade0b876", blk[31:0]); end
  endtask

  task automatic test_hold();
    logic [511:0] held, blk;
    int cnt, w;
    @(posedge clk); #1;
    t_ctr_init[1] = 64'd3; t_load[1] = 1'b1; t_start[1] = 1'b1;
    @(posedge clk); #1;
    t_start[1] = 1'b0; t_load[1] = 1'b0;
    cnt = 0;
    while (t_valid[1] !== 1'b1 && cnt < 200) begin @(posedge clk); #1; cnt++; end
    n_checks++;
    if (cnt != 20) begin n_fail++; $display("FAIL hold_latency: got %0d want 20", cnt); end
    held = t_block[1];
    n_checks++;
    if (held !== ref_block(256'd0, 96'd0, 64'd3, 64, 20)) begin n_fail++; $display("FAIL hold_block: got %h", held); end
    for (int c = 0; c < 10; c++) begin
      t_start[1] = (c == 4);
      t_key[1]   = {8{32'(c + 1)}};
      @(posedge clk); #1;
      n_checks++;
      if (t_valid[1] !== 1'b1 || t_inrdy[1] !== 1'b0) begin
        n_fail++; $display("FAIL hold_flags[%0d]: valid=%b in_ready=%b want 1/0", c, t_valid[1], t_inrdy[1]);
      end
      n_checks++;
      if (t_block[1] !== held) begin n_fail++; $display("FAIL hold_stable[%0d]: got %h want %h", c, t_block[1], held); end
    end
    t_start[1] = 1'b0; t_key[1] = '0;
    t_oready[1] = 1'b1;
    @(posedge clk); #1;
    t_oready[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (t_inrdy[1] !== 1'b1 || t_valid[1] !== 1'b0) begin
        n_fail++; $display("FAIL hold_not_queued[%0d]: in_ready=%b valid=%b want 1/0", c, t_inrdy[1], t_valid[1]);
      end
      @(posedge clk); #1;
    end
    run_block(1, 1'b0, 64'd0, 20, -1, 64'd0, blk, w);
    n_checks++;
    if (blk !== ref_block(256'd0, 96'd0, 64'd4, 64, 20)) begin n_fail++; $display("FAIL hold_next_ctr: got %h want ctr4 block", blk); end
  endtask

  task automatic test_load_in_flight();
    logic [511:0] blk;
    int w;
    run_block(1, 1'b1, 64'd10, 20, 5, 64'd500, blk, w);
    n_checks++;
    if (blk !== ref_block(256'd0, 96'd0, 64'd10, 64, 20)) begin n_fail++; $display("FAIL inflight_block: got %h want ctr10 block", blk); end
    run_block(1, 1'b0, 64'd0, 20, -1, 64'd0, blk, w);
    n_checks++;
    if (blk !== ref_block(256'd0, 96'd0, 64'd500, 64, 20)) begin n_fail++; $display("FAIL inflight_next: got %h want ctr500 block", blk); end
  endtask

  task automatic test_reset_mid_block();
    logic [511:0] blk;
    int w, seen;
    @(posedge clk); #1;
    t_ctr_init[1] = 64'd7; t_load[1] = 1'b1; t_start[1] = 1'b1;
    @(posedge clk); #1;
    t_start[1] = 1'b0; t_load[1] = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1; t_start[1] = 1'b1; t_load[1] = 1'b1; t_ctr_init[1] = 64'd9;
    @(posedge clk); #1;
    rst = 1'b0; t_start[1] = 1'b0; t_load[1] = 1'b0;
    n_checks++;
    if (t_inrdy[1] !== 1'b1 || t_valid[1] !== 1'b0 || t_block[1] !== 512'd0) begin
      n_fail++; $display("FAIL midrst_state: in_ready=%b valid=%b block_nonzero=%b", t_inrdy[1], t_valid[1], |t_block[1]);
    end
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (t_valid[1] !== 1'b0) seen++; end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d valid cycles want 0", seen); end
    run_block(1, 1'b0, 64'd0, 20, -1, 64'd0, blk, w);
    n_checks++;
    if (blk[31:0] !== 32'hade0b876) begin n_fail++; $display("FAIL midrst_ctr0_word0: got %h want ade0b876", blk[31:0]); end
  endtask

  task automatic test_rounds();
    logic [511:0] blk;
    int w;
    for (int j = 0; j < 8; j++) t_key[2][32*j +: 32] = 32'h01234567 ^ (32'(j) * 32'h9e3779b9);
    t_nonce[2] = {32'd0, 64'hfeedfacecafebeef};
    run_block(2, 1'b1, 64'h0123456789abcdef, 8, -1, 64'd0, blk, w);
    n_checks++;
    if (blk !== ref_block(t_key[2], t_nonce[2], 64'h0123456789abcdef, 64, 8)) begin
      n_fail++; $display("FAIL r8_block: got %h want %h", blk, ref_block(t_key[2], t_nonce[2], 64'h0123456789abcdef, 64, 8));
    end
    for (int j = 0; j < 8; j++) t_key[3][32*j +: 32] = 32'(j) * 32'h11111111 + 32'h0f;
    t_nonce[3] = 96'h0000004a_00000009_deadbeef;
    run_block(3, 1'b1, 64'd7, 12, -1, 64'd0, blk, w);
    n_checks++;
    if (blk !== ref_block(t_key[3], t_nonce[3], 64'd7, 32, 12)) begin
      n_fail++; $display("FAIL r12_block: got %h want %h", blk, ref_block(t_key[3], t_nonce[3], 64'd7, 32, 12));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      t_key[i] = '0; t_nonce[i] = '0; t_ctr_init[i] = '0;
      t_load[i] = 1'b0; t_start[i] = 1'b0; t_oready[i] = 1'b0;
    end
    test_reset();
    test_rfc_vector();
    test_back_to_back();
    test_wrap();
    test_hold();
    test_load_in_flight();
    test_reset_mid_block();
    test_rounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chacha_core_param.md
CHACHA_CORE_PARAM -- requirements
Module: chacha_core_param

Interface
REQ-001 Parameter ROUNDS, default 20, number of ChaCha rounds per block; legal values 8, 12, 20.
REQ-002 Parameter CTR_W, default 64, block-counter width; legal values 32, 64.
REQ-003 Derived NONCE_W = 128 - CTR_W, the nonce width (96 or 64).
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 key  in  256  key; key word j is key[32j+:32], placed in state word 4+j.
REQ-007 nonce  in  NONCE_W  nonce; nonce word k is nonce[32k+:32], placed in state word 12+CTR_W/32+k.
REQ-008 ctr_init  in  CTR_W  counter preload value.
REQ-009 ctr_load  in  1  when high, ctr_init is written to the internal counter.
REQ-010 start  in  1  request one keystream block; accepted only when in_ready=1.
REQ-011 in_ready  out  1  high only in IDLE.
REQ-012 block  out  512  keystream; state word i is block[32i+:32].
REQ-013 out_valid  out  1  block is valid; held until out_ready.
REQ-014 out_ready  in  1  consumer accepts block.
REQ-015 ctr_wrap  out  1  one-cycle pulse when the counter wraps from all-ones to 0.

Function
REQ-016 State words 0-3 SHALL be 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Word 12 SHALL be ctr[31:0]. For CTR_W=64, word 13 SHALL be ctr[63:32].
REQ-017 The FSM SHALL have the states IDLE, COL, DIAG and HOLD.
REQ-018 IDLE: on start, load the working and initial state registers, clear the round counter rc, and go to COL.
REQ-019 COL SHALL apply four quarter-rounds in parallel to (0,4,8,12), (1,5,9,13), (2,6,10,14) and (3,7,11,15), writing the results back in the same cycle, then go to DIAG.
REQ-020 DIAG SHALL apply quarter-rounds to (0,5,10,15), (1,6,11,12), (2,7,8,13) and (3,4,9,14), then increment rc by 2.
REQ-021 From DIAG, go to COL if rc+2 < ROUNDS; otherwise register block[i] = x[i] + init[i] (mod 2^32), set out_valid, and go to HOLD.
REQ-022 Quarter-round: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7. All additions are mod 2^32.
REQ-023 Latency: out_valid SHALL rise exactly ROUNDS cycles after the start-accept edge (20 cycles at the default).
REQ-024 HOLD: block and out_valid SHALL be stable while out_ready=0.
REQ-025 HOLD with out_ready=1: clear out_valid and return to IDLE; the next start is accepted no earlier than the following cycle.
REQ-026 The counter SHALL increment by 1 on every start accept, after its value is captured into the state.
REQ-027 On increment from all-ones, the counter SHALL wrap to 0 and ctr_wrap SHALL pulse for one cycle.
REQ-028 ctr_load together with an accepted start: ctr_init SHALL be used for that block, and the counter becomes ctr_init+1.
REQ-029 ctr_load outside an accept SHALL take effect in any state, without disturbing a block in flight.
REQ-030 start while in_ready=0 SHALL be ignored, not queued.
REQ-031 key and nonce SHALL be sampled only at the accept edge; later changes do not affect the block in flight.
REQ-032 Illegal ROUNDS or CTR_W SHALL cause an elaboration-time error.

Reset
REQ-033 rst SHALL force: state=IDLE, rc=0, counter=0, out_valid=0, block=0, ctr_wrap=0, in_ready=1 after the reset edge.
REQ-034 rst asserted mid-block or in HOLD SHALL abort the block with no out_valid pulse; rst has priority over start and ctr_load.

Verification
REQ-035 RFC 8439 2.3.2 vector (ROUNDS=20, CTR_W=32): key bytes 00..1f, nonce words {0x09000000, 0x4a000000, 0x00000000}, ctr_init=1 with ctr_load, start -> out_valid at cycle 20, block word0=0xe4e7f110.
REQ-036 All-zero key and nonce, counter 0, ROUNDS=20, CTR_W=64 -> block word0=0xade0b876; a second start gives the block for counter 1.
REQ-037 ctr_init=all-ones with ctr_load, two starts -> ctr_wrap pulses once after the first accept, and the second block uses counter 0.
REQ-038 Hold out_ready=0 for 10 cycles after out_valid -> block unchanged and in_ready=0 throughout; a start pulse in that window is ignored.
REQ-039 rst at cycle 7 of a block -> out_valid stays 0; a following start gives the block for counter 0 with correct latency.
REQ-040 ROUNDS=8 and ROUNDS=12 builds -> latency of 8 and 12 cycles, and block matches the reference-model output.
